// File: rtl/mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// mem_port_ctrl
//
// Initiator-side controller between the load/store stage and a single-port,
// 32-bit, word-addressed EAB RAM whose read path has two registers (address
// register on inclock, output register on outclock, both on clk). Loads are
// read, lane-extracted and sign/zero-extended. The RAM has no byte enables,
// so byte and halfword stores are done as read-modify-write.
//
// Optional feature macro: MEM_PORT_CTRL_MISALIGN_TRAP_EN
//   defined   : misaligned or illegal-size requests get an error response
//               (resp_err=1, resp_rdata=0) one cycle after accept, with no
//               RAM access.
//   undefined : resp_err is always 0; misaligned halfword/word addresses are
//               forced down to natural alignment and size 3 is treated as a
//               word access.
//
// Ports
//   clk            single clock (RAM inclock/outclock are tied to it)
//   rst_n          asynchronous active-low reset
//   req_valid      request present
//   req_ready      high in IDLE only
//   req_write      1 = store, 0 = load
//   req_size       0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned   zero-extend loads (ignored for stores)
//   req_addr       byte address, ADDR_WIDTH+2 bits
//   req_wdata      store data, LSB-aligned
//   resp_valid     one-cycle completion pulse, no backpressure
//   resp_rdata     extended load data; 0 for stores and errors
//   resp_err       error flag, valid with resp_valid
//   ram_we         registered RAM write enable (high only in WRITE)
//   ram_address    registered RAM word address
//   ram_data       registered RAM write data
//   ram_q          RAM read data (meaningful only in RD_C)
//   dbg_state      current FSM state encoding, for observation
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_ready depends only on the FSM state (never on
// req_valid), and all request fields are captured on that edge. The
// response side has no ready: resp_valid is a single-cycle pulse that the
// requester must take when it appears. Since req_ready returns high in the
// same cycle as resp_valid, the next request can be accepted in that cycle.
// -----------------------------------------------------------------------------
module mem_port_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_data,
    input  logic [31:0]           ram_q,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        RD_C  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    state_t state_q;
    state_t state_d;

    // Request fields captured on accept.
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    // Decoded view of the incoming request (after alignment handling).
    logic [1:0]  req_size_eff;
    logic [1:0]  req_lane_eff;
    logic        req_bad;
    logic        accept;

    // Next values of the registered outputs.
    logic                  resp_valid_d;
    logic [31:0]           resp_rdata_d;
    logic                  resp_err_d;
    logic                  ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_address_d;
    logic [31:0]           ram_data_d;

    // Read-data datapath.
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign dbg_state = state_q;

    // -------------------------------------------------------------------------
    // Request decode: either flag a bad request, or silently align it.
    // -------------------------------------------------------------------------
    always_comb begin
        req_size_eff = req_size;
        req_lane_eff = req_addr[1:0];
        req_bad      = 1'b0;
`ifdef MEM_PORT_CTRL_MISALIGN_TRAP_EN
        case (req_size)
            SZ_HALF: req_bad = req_addr[0];
            SZ_WORD: req_bad = |req_addr[1:0];
            SZ_ILL:  req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
`else
        case (req_size)
            SZ_HALF: req_lane_eff[0] = 1'b0;
            SZ_WORD, SZ_ILL: begin
                req_size_eff = SZ_WORD;
                req_lane_eff = 2'b00;
            end
            default: req_lane_eff = req_addr[1:0];
        endcase
`endif
    end

    // -------------------------------------------------------------------------
    // Request capture.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 32'd0;
        end else if (accept) begin
            write_q    <= req_write;
            size_q     <= req_size_eff;
            unsigned_q <= req_unsigned;
            lane_q     <= req_lane_eff;
            wdata_q    <= req_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Lane extraction for loads and lane merge for sub-word stores. Both use
    // ram_q, which is only meaningful while the FSM is in RD_C.
    // -------------------------------------------------------------------------
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = ram_q[7:0];
            2'd1:    byte_sel = ram_q[15:8];
            2'd2:    byte_sel = ram_q[23:16];
            default: byte_sel = ram_q[31:24];
        endcase
        half_sel = lane_q[1] ? ram_q[31:16] : ram_q[15:0];

        case (size_q)
            SZ_BYTE: load_ext = unsigned_q ? {24'd0, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_ext = unsigned_q ? {16'd0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            default: load_ext = ram_q;
        endcase

        merged = ram_q;
        case (size_q)
            SZ_BYTE: begin
                case (lane_q)
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane_q[1]) begin
                    merged[31:16] = wdata_q[15:0];
                end else begin
                    merged[15:0] = wdata_q[15:0];
                end
            end
            default: merged = wdata_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next-state and registered-output next values.
    // ram_we/resp_valid default low so they are single-state pulses;
    // ram_address/ram_data hold their last value unless updated.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = 32'd0;
        resp_err_d    = 1'b0;
        ram_we_d      = 1'b0;
        ram_address_d = ram_address;
        ram_data_d    = ram_data;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        // Error response next cycle; no RAM access.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        ram_address_d = req_addr[ADDR_WIDTH+1:2];
                        if (req_write && (req_size_eff == SZ_WORD)) begin
                            // Full word needs no read: write directly.
                            ram_we_d   = 1'b1;
                            ram_data_d = req_wdata;
                            state_d    = WRITE;
                        end else begin
                            state_d = RD_A;
                        end
                    end
                end
            end
            RD_A: state_d = RD_B;
            RD_B: state_d = RD_C;
            RD_C: begin
                if (write_q) begin
                    ram_we_d   = 1'b1;
                    ram_data_d = merged;
                    state_d    = WRITE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_ext;
                    state_d      = IDLE;
                end
            end
            WRITE: begin
                // The write happens on the edge leaving this state.
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. The async reset clears ram_we immediately,
    // so a reset during WRITE suppresses the pending RAM write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            resp_err    <= 1'b0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_data    <= 32'd0;
        end else begin
            state_q     <= state_d;
            resp_valid  <= resp_valid_d;
            resp_rdata  <= resp_rdata_d;
            resp_err    <= resp_err_d;
            ram_we      <= ram_we_d;
            ram_address <= ram_address_d;
            ram_data    <= ram_data_d;
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_port_ctrl
//
// Bench for mem_port_ctrl with an attached two-register-read RAM model. A
// reference memory and a request-level model predict every response (data,
// error flag, cycle) and every RAM write (address, data, cycle); a compare
// process checks them on every falling edge, together with req_ready.
// Directed cases pin the model with literal values; randomized requests
// follow. Build with +define+MEM_PORT_CTRL_MISALIGN_TRAP_EN to select the
// trapping variant.
// -----------------------------------------------------------------------------
module tb_mem_port_ctrl;

    localparam int AW = 8;

    // ---------------------------------------------------------------- clock/reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- DUT
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data;
    logic [31:0]   ram_q;
    logic [2:0]    dbg_state;

    mem_port_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_we       (ram_we),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_q        (ram_q),
        .dbg_state    (dbg_state)
    );

    // ---------------------------------------------------------------- RAM model
    logic [31:0]   seed_mem  [0:(1<<AW)-1];
    logic [31:0]   ram_mem   [0:(1<<AW)-1];
    logic [31:0]   model_mem [0:(1<<AW)-1];
    logic          mem_loaded = 1'b0;
    logic [AW-1:0] ram_addr_r = '0;
    logic [31:0]   ram_q_r = 32'd0;

    always @(posedge clk) begin
        if (!rst_n && !mem_loaded) begin
            for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= seed_mem[i];
            mem_loaded <= 1'b1;
        end else if (ram_we) begin
            ram_mem[ram_address] <= ram_data;
        end
        ram_addr_r <= ram_address;
        ram_q_r    <= ram_mem[ram_addr_r];
    end
    assign ram_q = ram_q_r;

    // ---------------------------------------------------------------- scoreboard
    int n_cmp  = 0;
    int n_fail = 0;

    // {due_cycle[31:0], err, rdata[31:0]}
    logic [64:0] exp_q[$];
    // {due_cycle[31:0], word_addr[7:0], data[31:0]}
    logic [71:0] wexp_q[$];
    int next_free = 0;

    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    int          last_resp_cyc = 0;
    logic [31:0] last_we_data = 32'd0;
    int          last_we_cyc = 0;
    int          we_pulses = 0;
    int          last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [64:0] e;
        logic [71:0] w;
        if (rst_n) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, (cyc >= next_free)});

            if (resp_valid) begin
                last_rdata    = resp_rdata;
                last_err      = resp_err;
                last_resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("resp_valid unexpected", {31'd0, resp_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e[31:0]);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
                    chk("resp cycle", cyc, e[64:33]);
                end
            end else if (exp_q.size() != 0 && int'(exp_q[0][64:33]) < cyc) begin
                chk("resp_valid missing", {31'd0, resp_valid}, 32'd1);
                e = exp_q.pop_front();
            end

            if (ram_we) begin
                we_pulses++;
                last_we_data = ram_data;
                last_we_cyc  = cyc;
                if (wexp_q.size() == 0) begin
                    chk("ram_we unexpected", {31'd0, ram_we}, 32'd0);
                end else begin
                    w = wexp_q.pop_front();
                    chk("ram_address", {24'd0, ram_address}, {24'd0, w[39:32]});
                    chk("ram_data", ram_data, w[31:0]);
                    chk("write cycle", cyc, w[71:40]);
                end
            end else if (wexp_q.size() != 0 && int'(wexp_q[0][71:40]) < cyc) begin
                chk("ram_we missing", {31'd0, ram_we}, 32'd1);
                w = wexp_q.pop_front();
            end
        end
    end

    // ---------------------------------------------------------------- model
    function automatic logic [31:0] ext_load(input logic [31:0] word, input int sz,
                                             input logic uns, input logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> (8 * lane);
        if (sz == 0) return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        if (sz == 1) return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        return word;
    endfunction

    // ---------------------------------------------------------------- driver
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (!req_ready) chk("req_ready timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || wexp_q.size() != 0) && n < 40) begin
            step();
            n++;
        end
        if (exp_q.size() != 0 || wexp_q.size() != 0)
            chk("drain timeout", exp_q.size() + wexp_q.size(), 32'd0);
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz_in, input logic uns,
                          input logic [AW+1:0] addr, input logic [31:0] wd);
        int          sz;
        int          lat;
        int          acc;
        logic [1:0]  lane;
        logic        err;
        logic [31:0] old;
        logic [31:0] rd;
        logic [31:0] mask;
        logic [31:0] nw;
        logic [31:0] due;
        logic [AW-1:0] wi;
        wait_ready();
        sz   = int'(sz_in);
        lane = addr[1:0];
        err  = 1'b0;
        wi   = addr[AW+1:2];
`ifdef MEM_PORT_CTRL_MISALIGN_TRAP_EN
        if (sz == 3 || (sz == 1 && lane[0]) || (sz == 2 && lane != 2'd0)) err = 1'b1;
`else
        if (sz == 3) sz = 2;
        if (sz == 1) lane[0] = 1'b0;
        if (sz == 2) lane = 2'd0;
`endif
        acc = cyc + 1;
        old = model_mem[wi];
        rd  = 32'd0;
        if (err) begin
            lat = 1;
        end else if (!wr) begin
            lat = 4;
            rd  = ext_load(old, sz, uns, lane);
        end else begin
            mask = (sz == 0) ? 32'h0000_00FF : (sz == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            mask = mask << (8 * lane);
            nw   = (old & ~mask) | ((wd << (8 * lane)) & mask);
            model_mem[wi] = nw;
            lat = (sz == 2) ? 2 : 5;
            due = 32'(acc + lat - 2);
            wexp_q.push_back({due, wi, nw});
        end
        due = 32'(acc + lat - 1);
        exp_q.push_back({due, err, rd});
        next_free = acc + lat - 1;
        last_acc  = acc;

        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz_in;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " req_ready"},   {31'd0, req_ready},  32'd1);
        chk({tag, " resp_valid"},  {31'd0, resp_valid}, 32'd0);
        chk({tag, " resp_rdata"},  resp_rdata,          32'd0);
        chk({tag, " resp_err"},    {31'd0, resp_err},   32'd0);
        chk({tag, " ram_we"},      {31'd0, ram_we},     32'd0);
        chk({tag, " ram_address"}, {24'd0, ram_address}, 32'd0);
        chk({tag, " ram_data"},    ram_data,            32'd0);
        chk({tag, " state"},       {29'd0, dbg_state},  32'd0);
    endtask

    // Load with literal pin of data, error flag and latency.
    task automatic pin_load(input string name, input logic [1:0] sz, input logic uns,
                            input logic [AW+1:0] addr, input logic [31:0] exp_data);
        do_req(1'b0, sz, uns, addr, 32'd0);
        wait_done();
        chk({name, " data"}, last_rdata, exp_data);
        chk({name, " err"}, {31'd0, last_err}, 32'd0);
        chk({name, " latency"}, 32'(last_resp_cyc - last_acc + 1), 32'd4);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1);
    end

    // ---------------------------------------------------------------- main
    initial begin
        int we0;
        for (int i = 0; i < (1 << AW); i++) begin
            seed_mem[i]  = $urandom();
            model_mem[i] = seed_mem[i];
        end

        // Reset state.
        repeat (3) step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();

        // Word store then word load.
        do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEAD_BEEF);
        wait_done();
        chk("SW latency", 32'(last_resp_cyc - last_acc + 1), 32'd2);
        chk("SW rdata", last_rdata, 32'd0);
        pin_load("LW 0x10", 2'd2, 1'b0, 10'h010, 32'hDEAD_BEEF);

        // Lane extraction.
        pin_load("LB 0x13",  2'd0, 1'b0, 10'h013, 32'hFFFF_FFDE);
        pin_load("LBU 0x13", 2'd0, 1'b1, 10'h013, 32'h0000_00DE);
        pin_load("LH 0x10",  2'd1, 1'b0, 10'h010, 32'hFFFF_BEEF);
        pin_load("LHU 0x12", 2'd1, 1'b1, 10'h012, 32'h0000_DEAD);

        // Sub-word store (read-modify-write).
        we0 = we_pulses;
        do_req(1'b1, 2'd0, 1'b0, 10'h011, 32'h0000_0055);
        wait_done();
        chk("SB write count", 32'(we_pulses - we0), 32'd1);
        chk("SB ram_data", last_we_data, 32'hDEAD_55EF);
        chk("SB write cycle", 32'(last_we_cyc - last_acc + 1), 32'd4);
        chk("SB latency", 32'(last_resp_cyc - last_acc + 1), 32'd5);
        pin_load("LW after SB", 2'd2, 1'b0, 10'h010, 32'hDEAD_55EF);

`ifdef MEM_PORT_CTRL_MISALIGN_TRAP_EN
        we0 = we_pulses;
        do_req(1'b0, 2'd1, 1'b0, 10'h011, 32'd0);
        wait_done();
        chk("LH 0x11 err", {31'd0, last_err}, 32'd1);
        chk("LH 0x11 rdata", last_rdata, 32'd0);
        chk("LH 0x11 latency", 32'(last_resp_cyc - last_acc + 1), 32'd1);
        do_req(1'b1, 2'd2, 1'b0, 10'h012, 32'hCAFE_F00D);
        wait_done();
        chk("SW 0x12 err", {31'd0, last_err}, 32'd1);
        chk("SW 0x12 latency", 32'(last_resp_cyc - last_acc + 1), 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 10'h010, 32'd0);
        wait_done();
        chk("size3 err", {31'd0, last_err}, 32'd1);
        chk("size3 rdata", last_rdata, 32'd0);
        chk("error write count", 32'(we_pulses - we0), 32'd0);
`else
        pin_load("LW 0x13 aligned", 2'd2, 1'b0, 10'h013, 32'hDEAD_55EF);
`endif

        // Reset during WRITE of a word store: the write must not happen.
        do_req(1'b1, 2'd2, 1'b0, 10'h020, 32'hA5A5_0F0F);
        wait_done();
        wait_ready();
        we0 = we_pulses;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 10'h020;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("ram_we in WRITE", {31'd0, ram_we}, 32'd1);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("ram_we async clear", {31'd0, ram_we}, 32'd0);
        step();
        check_reset_values("mid reset");
        step();
        rst_n = 1'b1;
        step();
        chk("aborted write count", 32'(we_pulses - we0), 32'd0);
        pin_load("LW 0x20 after reset", 2'd2, 1'b0, 10'h020, 32'hA5A5_0F0F);

        // Randomized traffic, sometimes back to back.
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), $urandom());
        end
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Initiator-side controller that turns CPU load/store requests into accesses on a single-port, 32-bit-wide, word-addressed EAB RAM with a two-register read path (read data valid two clock edges after the address edge). It sits between the load/store stage and the data RAM. The RAM has no byte enables, so the controller performs byte and halfword stores as read-modify-write. It also performs load lane extraction and sign/zero extension.

## Interface
- ADDR_WIDTH, 8, RAM word-address width; byte address is ADDR_WIDTH+2 bits.
- clk  in  1  single clock; RAM inclock and outclock are both tied to it.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high in IDLE only; a request is accepted on a clk edge with req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for stores.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; set for misaligned or illegal-size requests.
- ram_we, ram_address[ADDR_WIDTH-1:0], ram_data[31:0]  out  registered RAM controls.
- ram_q  in  32  RAM read data.

## Operation
- FSM states: IDLE, RD_A, RD_B, RD_C, WRITE.
- All request fields are latched on accept.
- Load: IDLE → RD_A → RD_B → RD_C → IDLE.
  - ram_address is held at req_addr[ADDR_WIDTH+1:2] from RD_A through RD_C.
  - In RD_C, ram_q is valid.
  - Lane selection: byte lane = addr[1:0], half lane = addr[1].
  - The selected lane is sign- or zero-extended and registered into resp_rdata.
- Word store: IDLE → WRITE → IDLE. ram_we=1 and ram_data=wdata during WRITE.
- Sub-word store: IDLE → RD_A → RD_B → RD_C → WRITE → IDLE.
  - In RD_C, the addressed lane(s) of ram_q are replaced with wdata[7:0] or wdata[15:0].
  - The merged word is driven as ram_data in WRITE.
- resp_valid pulses in the cycle after RD_C (load) or after WRITE (store), with resp_err=0.
- Error detection (with the Configuration macro defined):
  - Error conditions: size 3, half with addr[0]=1, or word with addr[1:0]≠0.
  - Result: no RAM access, ram_we stays 0, FSM stays IDLE.
  - resp_valid=1, resp_err=1, resp_rdata=0 in the next cycle.
- ram_we is high only in WRITE.
- Because req_ready is high only in IDLE, a new request may be accepted in the same cycle resp_valid is high.

## Timing
- Accept edge = end of cycle 0.
- Load: resp_valid in cycle 4.
- Word store: RAM write edge ends cycle 1; resp_valid in cycle 2.
- Sub-word store: write edge ends cycle 4; resp_valid in cycle 5.
- Error response: resp_valid in cycle 1; FSM stays IDLE, so req_ready stays high.
- Back-to-back loads: one per 4 cycles. Back-to-back word stores: one per 2 cycles.
- Reset values: FSM IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, ram_we 0, ram_address 0, ram_data 0.
- Reset mid-operation: the operation is aborted with no response.
  - If rst_n falls during WRITE before the write edge, ram_we clears asynchronously and the RAM is not written.
- The RAM's own read register is not reset; the controller never consumes ram_q outside RD_C.

## Configuration
- MEM_PORT_CTRL_MISALIGN_TRAP_EN defined:
  - Misaligned or illegal-size requests produce the resp_err response described above.
- Undefined:
  - resp_err is tied to 0.
  - Misaligned halfword addresses are forced to addr[0]=0; misaligned word addresses are forced to addr[1:0]=0.
  - Size 3 is treated as word.
  - The access then proceeds normally with standard latency.

## Test plan
- Word store 0xDEADBEEF to byte addr 0x10, then LW 0x10.
  - Store: resp_valid in cycle 2.
  - Load: resp_rdata=0xDEADBEEF in cycle 4, resp_err=0.
- With word 0x10 = 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x10 → 0xFFFFBEEF.
  - LHU 0x12 → 0x0000DEAD.
- SB 0x55 to 0x11 on word 0xDEADBEEF.
  - ram_we high only in cycle 4, with ram_data=0xDEAD55EF.
  - resp_valid in cycle 5; a following LW returns 0xDEAD55EF.
- With the macro defined:
  - LH 0x11 → resp_err=1, resp_rdata=0 in cycle 1, ram_we never asserted.
  - SW 0x12 → same error response.
  - size=3 → same error response.
- Without the macro: LW 0x13 returns the word at 0x10 and resp_err=0.
- rst_n asserted in WRITE of an SW 0x12345678 to 0x20 → no write; a post-reset LW 0x20 returns the prior contents; all outputs show reset values while rst_n is low.
